// File: rtl/ysyx_23060208_mem_responder.sv
// Memory-side target for the valid/ready request interface: accepts one word
// access, waits a fixed latency, then holds the response until it is taken.
module ysyx_23060208_mem_responder #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             DEPTH_LOG2 = 10,
  parameter int unsigned             LATENCY    = 3,
  parameter logic [DATA_WIDTH-1:0]   BASE_ADDR  = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [DATA_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-3:0]   word_off;
  logic [DEPTH_LOG2-1:0]   index;
  logic                    addr_err;
  logic                    access;

  // Word offset is computed on word addresses so no low bits go unused;
  // the below-base case is caught separately since the subtraction wraps.
  assign word_off = addr_q[DATA_WIDTH-1:2] - BASE_ADDR[DATA_WIDTH-1:2];
  assign index    = word_off[DEPTH_LOG2-1:0];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                    (word_off[DATA_WIDTH-3:DEPTH_LOG2] != '0);
  assign access   = (state == BUSY) && (cnt == '0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_err   <= addr_err;
            resp_rdata <= (addr_err || wen_q) ? '0 : mem[index];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset on the access edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && access && wen_q && !addr_err) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) mem[index][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_responder.sv
// Bench for ysyx_23060208_mem_responder: table of accesses on a LATENCY=3
// instance, reset-drop sequence, and back-to-back traffic on a LATENCY=1 instance.
module tb_ysyx_23060208_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;

  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wstrb;

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  exp_t sb[$];
  vec_t vq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_23060208_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT),
                                .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  ysyx_23060208_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1),
                                .BASE_ADDR(32'h8000_0000)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int          n;
    logic [31:0] hr;
    logic        he;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(posedge clk); #1;
    sb.push_back('{v.exp_rdata, v.exp_err});
    // Scramble the request bus after acceptance; it must not matter.
    req_valid = 1'b0; req_wen = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'hF;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, LAT);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rdata", resp_rdata, e.rdata);
      check("err", {31'd0, resp_err}, {31'd0, e.err});
    end
    hr = resp_rdata; he = resp_err;
    for (int i = 0; i < v.hold; i++) begin
      req_valid = i[0];
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rdata", resp_rdata, hr);
      check("hold_err", {31'd0, resp_err}, {31'd0, he});
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_valid", {31'd0, resp_valid}, 32'd0);
    check("post_ready", {31'd0, req_ready}, 32'd1);
    check("post_rdata", resp_rdata, 32'd0);
    check("post_err", {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    vq.push_back(mk(1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 0));
    vq.push_back(mk(1, 32'h8000_0010, 32'h1234_5678, 4'hF, 0, 32'h0, 0));
    vq.push_back(mk(0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'h1234_5678, 0));
    vq.push_back(mk(1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 0, 32'h0, 0));
    vq.push_back(mk(1, 32'h8000_0020, 32'h1122_3344, 4'h5, 0, 32'h0, 0));
    vq.push_back(mk(0, 32'h8000_0020, 32'h0,         4'h0, 5, 32'hAA22_CC44, 0));
    vq.push_back(mk(1, 32'h8000_0FFC, 32'hCAFE_BABE, 4'hF, 0, 32'h0, 0));
    vq.push_back(mk(0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 32'hCAFE_BABE, 0));
    vq.push_back(mk(1, 32'h8000_0004, 32'h0102_0304, 4'hF, 0, 32'h0, 0));
    vq.push_back(mk(1, 32'h8000_0004, 32'h5555_5555, 4'h0, 2, 32'h0, 0));
    vq.push_back(mk(0, 32'h8000_0004, 32'h0,         4'h0, 0, 32'h0102_0304, 0));
    vq.push_back(mk(0, 32'h8000_0002, 32'h0,         4'h0, 0, 32'h0, 1));
    vq.push_back(mk(0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 32'h0, 1));
    vq.push_back(mk(1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 3, 32'h0, 1));
    vq.push_back(mk(1, 32'h8000_0FFE, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1));
    vq.push_back(mk(0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 32'h0, 1));
    vq.push_back(mk(0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0BAD_F00D, 0));
    vq.push_back(mk(0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 32'hCAFE_BABE, 0));

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);

    foreach (vq[i]) run_vec(vq[i]);

    // Reset during BUSY of a write: the write must be dropped.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0000;
    req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    check("midrst_err", {31'd0, resp_err}, 32'd0);
    run_vec(mk(0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 0));

    // LATENCY=1 instance, resp_ready held high: accepts every 3 cycles.
    begin
      vec_t bv[3];
      int   acc, prev_acc, n;
      logic rdy;
      exp_t e;
      bv[0] = mk(1, 32'h8000_0014, 32'h7766_5544, 4'hF, 0, 32'h0, 0);
      bv[1] = mk(0, 32'h8000_0014, 32'h0,         4'h0, 0, 32'h7766_5544, 0);
      bv[2] = mk(0, 32'h8000_1000, 32'h0,         4'h0, 0, 32'h0, 1);
      prev_acc = 0;
      b_resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        b_req_valid = 1'b1; b_req_wen = bv[i].wen; b_req_addr = bv[i].addr;
        b_req_wdata = bv[i].wdata; b_req_wstrb = bv[i].wstrb;
        n = 0;
        do begin
          rdy = b_req_ready;
          @(posedge clk); #1; n++;
        end while (!rdy && n < 10);
        acc = cyc;
        sb.push_back('{bv[i].exp_rdata, bv[i].exp_err});
        b_req_valid = 1'b0;
        if (i > 0) check("l1_spacing", acc - prev_acc, 32'd3);
        prev_acc = acc;
        check("l1_busy_valid", {31'd0, b_resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("l1_resp_valid", {31'd0, b_resp_valid}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("l1_rdata", b_resp_rdata, e.rdata);
          check("l1_err", {31'd0, b_resp_err}, {31'd0, e.err});
        end
      end
      @(posedge clk); #1;
      b_resp_ready = 1'b0;
      check("l1_final_ready", {31'd0, b_req_ready}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
